// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-slave SPI master, all four modes; `define SPI_LSB_FIRST_EN adds lsb_first_i for LSB-first frames
module spi_master_mc #(
  parameter int WIDTH = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W = 8,
  parameter int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [SS_W-1:0]   ss_idx_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic [WIDTH-1:0]  data_tx_i,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first_i,
`endif
  output logic [WIDTH-1:0]  data_rx_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_SS-1:0] ss_n_o
);
  localparam int EW = $clog2(2 * WIDTH + 1);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;
  state_t st;
  logic [DIV_W-1:0] cnt, hm;
  logic [EW-1:0] ecnt;
  logic cpha_l, lsb_l, lsb_sel, half_end, edge_ev, smp, last;
  logic [WIDTH-1:0] tx_sh, rx_sh, tx_ord;
`ifdef SPI_LSB_FIRST_EN
  assign lsb_sel = lsb_first_i;
`else
  assign lsb_sel = 1'b0;
`endif
  // LSB-first transmit is done by reversing the frame once at accept and always shifting from the top
  for (genvar i = 0; i < WIDTH; i++) begin : g_ord
    assign tx_ord[i] = lsb_sel ? data_tx_i[WIDTH-1-i] : data_tx_i[i];
  end
  assign half_end = cnt == hm;
  assign edge_ev = half_end && (st == SETUP || (st == XFER && ecnt != EW'(2 * WIDTH)));
  assign smp = ~ecnt[0] ^ cpha_l;
  assign last = ecnt == EW'(2 * WIDTH - 1);
  // transfer sequencer: SCLK edges, shifting and all registered outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      st <= IDLE;
      sclk_o <= 1'b0;
      mosi_o <= 1'b0;
      ss_n_o <= '1;
      busy_o <= 1'b0;
      rx_valid_o <= 1'b0;
      err_o <= 1'b0;
      data_rx_o <= '0;
      cnt <= '0;
      hm <= '0;
      ecnt <= '0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
      tx_sh <= '0;
      rx_sh <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      err_o <= 1'b0;
      cnt <= half_end ? '0 : cnt + DIV_W'(1);
      if (edge_ev) begin
        sclk_o <= ~sclk_o;
        ecnt <= ecnt + EW'(1);
        if (smp) rx_sh <= lsb_l ? {miso_i, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], miso_i};
        else if (!last) begin
          mosi_o <= tx_sh[WIDTH-1];
          tx_sh <= tx_sh << 1;
        end
      end
      case (st)
        IDLE: begin
          cnt <= '0;
          if (start_i && 32'(ss_idx_i) < 32'(NUM_SS)) begin
            st <= SETUP;
            busy_o <= 1'b1;
            ss_n_o <= ~(NUM_SS'(1) << ss_idx_i);
            sclk_o <= cpol_i;
            hm <= clk_div_i;
            cpha_l <= cpha_i;
            lsb_l <= lsb_sel;
            ecnt <= '0;
            rx_sh <= '0;
            if (!cpha_i) mosi_o <= tx_ord[WIDTH-1];
            tx_sh <= cpha_i ? tx_ord : tx_ord << 1;
          end else if (start_i) err_o <= 1'b1;
        end
        SETUP: if (half_end) st <= XFER;
        XFER: if (half_end && ecnt == EW'(2 * WIDTH)) st <= HOLD;
        HOLD: if (half_end) begin
          st <= DONE;
          ss_n_o <= '1;
          data_rx_o <= rx_sh;
          rx_valid_o <= 1'b1;
        end
        DONE: begin
          st <= IDLE;
          busy_o <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
